// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo: parameter sanity math and occupancy-count width.
// Optional level output is enabled by defining SYNC_FIFO_LEVEL_EN.
package sync_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // The count must reach depth itself, so it needs one bit more than a pointer.
  function automatic int unsigned count_width(input int unsigned depth_log);
    return depth_log + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// depth x width storage for sync_fifo: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module sync_fifo_mem #(
  parameter int width     = 32,
  parameter int depth     = 4,
  parameter int depth_LOG = 2
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [depth_LOG-1:0] waddr_i,
  input  logic [width-1:0]     wdata_i,
  input  logic [depth_LOG-1:0] raddr_i,
  output logic [width-1:0]     rdata_o
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with FWFT or registered-read output; flags decode registered count only.
// Define SYNC_FIFO_LEVEL_EN to expose the occupancy count on level_o.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int width     = 32,
  parameter int depth     = 4,
  parameter int depth_LOG = 2,
  parameter int FWFT      = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [width-1:0]   data_i,
  output logic               full_o,
  output logic               empty_o,
`ifdef SYNC_FIFO_LEVEL_EN
  output logic [depth_LOG:0] level_o,
`endif
  output logic [width-1:0]   data_o
);

  localparam int unsigned CNT_W = count_width(depth_LOG);

  if (depth < 2 || clog2(depth) != depth_LOG || (1 << depth_LOG) != depth) begin : g_bad_param
    $error("sync_fifo: depth must be a power of two >= 2 with depth_LOG = log2(depth)");
  end

  logic [depth_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [width-1:0]     rdata;
  logic                 wr_en, rd_en;

  assign full_o  = (count_q == CNT_W'(depth));
  assign empty_o = (count_q == '0);
  assign wr_en   = write_i & ~full_o;
  assign rd_en   = read_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + depth_LOG'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + depth_LOG'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sync_fifo_mem #(
    .width    (width),
    .depth    (depth),
    .depth_LOG(depth_LOG)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_i),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign data_o = empty_o ? '0 : rdata;
  end else begin : g_reg
    logic [width-1:0] data_q;
    // Captures the head being popped, so the value lands one edge after the read.
    always_ff @(posedge clk) begin
      if (!rstn)      data_q <= '0;
      else if (rd_en) data_q <= rdata;
    end
    assign data_o = data_q;
  end

`ifdef SYNC_FIFO_LEVEL_EN
  assign level_o = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one FWFT instance and one registered-read instance, 8-bit x 4.
// Level checks are included when SYNC_FIFO_LEVEL_EN is defined.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       f_rd = 1'b0, f_wr = 1'b0;
  logic [7:0] f_din = '0;
  logic       f_full, f_empty;
  logic [7:0] f_dout;
  logic       r_rd = 1'b0, r_wr = 1'b0;
  logic [7:0] r_din = '0;
  logic       r_full, r_empty;
  logic [7:0] r_dout;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [2:0] f_level, r_level;
`endif

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  sync_fifo #(.width(8), .depth(4), .depth_LOG(2), .FWFT(1)) u_fwft (
    .clk(clk), .rstn(rstn), .read_i(f_rd), .write_i(f_wr), .data_i(f_din),
    .full_o(f_full), .empty_o(f_empty),
`ifdef SYNC_FIFO_LEVEL_EN
    .level_o(f_level),
`endif
    .data_o(f_dout)
  );

  sync_fifo #(.width(8), .depth(4), .depth_LOG(2), .FWFT(0)) u_reg (
    .clk(clk), .rstn(rstn), .read_i(r_rd), .write_i(r_wr), .data_i(r_din),
    .full_o(r_full), .empty_o(r_empty),
`ifdef SYNC_FIFO_LEVEL_EN
    .level_o(r_level),
`endif
    .data_o(r_dout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic fop(input logic rd, input logic wr, input logic [7:0] d);
    f_rd = rd; f_wr = wr; f_din = d;
    @(posedge clk); #1;
    f_rd = 1'b0; f_wr = 1'b0;
  endtask

  task automatic rop(input logic rd, input logic wr, input logic [7:0] d);
    r_rd = rd; r_wr = wr; r_din = d;
    @(posedge clk); #1;
    r_rd = 1'b0; r_wr = 1'b0;
  endtask

  initial begin
    // Reset
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_empty", 32'(f_empty), 32'd1);
    check_eq("rst_full", 32'(f_full), 32'd0);
    check_eq("rst_dout", 32'(f_dout), 32'h0);
    check_eq("rst_r_empty", 32'(r_empty), 32'd1);
    check_eq("rst_r_dout", 32'(r_dout), 32'h0);
`ifdef SYNC_FIFO_LEVEL_EN
    check_eq("rst_level", 32'(f_level), 32'd0);
`endif
    rstn = 1'b1;
    fop(1'b1, 1'b0, 8'h00);
    check_eq("rd_empty_empty", 32'(f_empty), 32'd1);
    check_eq("rd_empty_dout", 32'(f_dout), 32'h0);

    // FWFT single word
    fop(1'b0, 1'b1, 8'hA1);
    check_eq("fwft_dout", 32'(f_dout), 32'hA1);
    check_eq("fwft_nempty", 32'(f_empty), 32'd0);
    fop(1'b0, 1'b0, 8'h00);
    check_eq("fwft_hold", 32'(f_dout), 32'hA1);
    fop(1'b1, 1'b0, 8'h00);
    check_eq("fwft_rd_empty", 32'(f_empty), 32'd1);
    check_eq("fwft_rd_dout", 32'(f_dout), 32'h0);

    // Fill, overflow drop, drain
    for (int i = 1; i <= 4; i++) begin
      fop(1'b0, 1'b1, 8'(i));
      check_eq("fill_full", 32'(f_full), (i == 4) ? 32'd1 : 32'd0);
    end
    fop(1'b0, 1'b1, 8'h05);
    check_eq("ovf_full", 32'(f_full), 32'd1);
    check_eq("ovf_head", 32'(f_dout), 32'h01);
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_data", 32'(f_dout), 32'(i));
      fop(1'b1, 1'b0, 8'h00);
    end
    check_eq("drain_empty", 32'(f_empty), 32'd1);

    // Wrap: pointers cycle 2.5 times with occupancy never above 1
    for (int i = 0; i < 10; i++) begin
      fop(1'b0, 1'b1, 8'(8'h10 + i));
      check_eq("wrap_data", 32'(f_dout), 32'(8'h10 + i));
      check_eq("wrap_full", 32'(f_full), 32'd0);
`ifdef SYNC_FIFO_LEVEL_EN
      check_eq("wrap_level1", 32'(f_level), 32'd1);
`endif
      fop(1'b1, 1'b0, 8'h00);
      check_eq("wrap_empty", 32'(f_empty), 32'd1);
    end

    // Simultaneous read+write with two entries held
    fop(1'b0, 1'b1, 8'h20);
    fop(1'b0, 1'b1, 8'h21);
    for (int i = 0; i < 3; i++) begin
      check_eq("sim_head", 32'(f_dout), 32'(8'h20 + i));
      fop(1'b1, 1'b1, 8'(8'h22 + i));
      check_eq("sim_full", 32'(f_full), 32'd0);
      check_eq("sim_empty", 32'(f_empty), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      check_eq("sim_drain", 32'(f_dout), 32'(8'h23 + i));
      fop(1'b1, 1'b0, 8'h00);
    end
    check_eq("sim_drain_empty", 32'(f_empty), 32'd1);

    // Read+write while full: the write is dropped
    for (int i = 0; i < 4; i++) fop(1'b0, 1'b1, 8'(8'h30 + i));
    check_eq("frw_full_pre", 32'(f_full), 32'd1);
    fop(1'b1, 1'b1, 8'h99);
    check_eq("frw_full", 32'(f_full), 32'd0);
    check_eq("frw_head", 32'(f_dout), 32'h31);
`ifdef SYNC_FIFO_LEVEL_EN
    check_eq("frw_level", 32'(f_level), 32'd3);
`endif
    for (int i = 1; i < 4; i++) begin
      check_eq("frw_drain", 32'(f_dout), 32'(8'h30 + i));
      fop(1'b1, 1'b0, 8'h00);
    end
    check_eq("frw_empty", 32'(f_empty), 32'd1);

    // Registered-read mode
    rop(1'b0, 1'b1, 8'h55);
    check_eq("reg_wr_dout", 32'(r_dout), 32'h0);
    check_eq("reg_wr_empty", 32'(r_empty), 32'd0);
`ifdef SYNC_FIFO_LEVEL_EN
    check_eq("reg_level1", 32'(r_level), 32'd1);
`endif
    rop(1'b1, 1'b0, 8'h00);
    check_eq("reg_rd_dout", 32'(r_dout), 32'h55);
    check_eq("reg_rd_empty", 32'(r_empty), 32'd1);
`ifdef SYNC_FIFO_LEVEL_EN
    check_eq("reg_level0", 32'(r_level), 32'd0);
`endif
    rop(1'b0, 1'b0, 8'h00);
    check_eq("reg_hold", 32'(r_dout), 32'h55);
    rop(1'b1, 1'b0, 8'h00);
    check_eq("reg_rd_empty_hold", 32'(r_dout), 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
